dab_tps_modulator: RTL and testbench
====================================

# dab_tps_modulator

Triple-phase-shift carrier generator for the dual-active-bridge power stage. It produces the three-level voltage commands V1 (primary) and V2 (secondary), using the codes 01 = +1, 00 = 0 and 11 = −1, plus the clock-enable strobe consumed by the downstream bridge switching/deadtime stage. Period, inner-bridge zero widths and the inter-bridge phase shift are shadow-registered so they take effect only at carrier wrap.

## Interface
- DIV, 1: prescaler ratio. One carrier tick every DIV clk cycles, DIV ≥ 1.
- CNT_W, 16: width of the carrier counter and of all timing inputs.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  run enable; low holds the carrier at 0 and forces V1 = V2 = 00
- period  in  CNT_W  carrier period in ticks (P)
- d1  in  CNT_W  primary zero-state width per half period, in ticks
- d2  in  CNT_W  secondary zero-state width per half period, in ticks
- phi  in  CNT_W  secondary lag behind primary, in ticks
- V1  out  2  primary level command
- V2  out  2  secondary level command
- ce_out  out  1  one-clk strobe marking V1/V2 valid for the downstream stage
- sync  out  1  one-clk pulse when the carrier is at count 0
- cfg_err  out  1  shadowed configuration invalid; outputs forced 00

## Operation
- Prescaler counts 0..DIV−1 and raises internal tick at DIV−1. It runs whenever rst is low, independent of en, so ce_out keeps pulsing while en is low.
- Shadow registers P_s, d1_s, d2_s and phi_s:
  - load from the inputs every tick while en = 0;
  - load on the tick where cnt = P_s−1, i.e. the wrap, while en = 1;
  - are otherwise held. Mid-period input changes have no effect until the wrap.
- cfg_err = (P_s < 4) or (phi_s ≥ P_s). It is evaluated from the shadows. While it is set:
  - cnt is held at 0;
  - V1 = V2 = 00;
  - sync is suppressed.
- Carrier:
  - on each tick with en = 1 and cfg_err = 0: cnt ← (cnt = P_s−1) ? 0 : cnt+1;
  - en = 0 forces cnt ← 0.
- Half period H = P_s >> 1. For odd P the second half is one tick longer.
- Secondary count c2 = cnt − phi_s when cnt ≥ phi_s, else cnt + P_s − phi_s. Computed in CNT_W+1 bits, no overflow.
- Level function f(c, d):
  - c < H: 00 if c < d, else 01;
  - c ≥ H: 00 if (c−H) < d, else 11.
  - d ≥ H (or d ≥ P−H in the second half) yields a constant 00 for that half. This is a legal clamp, not an error.
- Outputs:
  - V1 = f(cnt, d1_s) and V2 = f(c2, d2_s);
  - both are forced to 00 when en = 0 or cfg_err = 1;
  - code 10 is never emitted.

## Timing
- Reset values: cnt = 0, prescaler = 0, all shadows = 0, V1 = 00, V2 = 00, ce_out = 0, sync = 0, cfg_err = 1. cfg_err is 1 because P_s = 0.
- Cycle T (tick high): cnt and the shadows update at the edge ending T.
- T+1: V1, V2 and sync are registered from the new cnt. Latency from tick to output is 1 clk.
- T+2: ce_out is high for exactly one clk, with V1/V2 already stable for one cycle. The downstream deadtime counter therefore advances once per carrier tick.
- sync is high in the same cycle in which V1/V2 reflect cnt = 0.
- en rising:
  - the first tick after it loads the shadows;
  - cnt stays 0 for that tick;
  - counting starts on the next tick.
- en falling: the next tick forces cnt = 0, and V1 = V2 = 00 one clk later.
- rst mid-period: all state clears asynchronously. After rst deasserts, the prescaler restarts from 0 and the first tick occurs DIV clks later.
- DIV = 1: tick every clk, ce_out continuously high from the third cycle after reset release.

## Test plan
- Reset: assert rst mid-run → V1 = V2 = 00, ce_out = 0, sync = 0, cfg_err = 1 immediately, asynchronous with clk.
- Basic TPS: DIV = 1, P = 8, d1 = 1, d2 = 2, phi = 2, en = 1 → per carrier count 0..7:
  - V1 = 00,01,01,01,00,11,11,11;
  - V2 = 11,11,00,00,01,01,00,00;
  - sync every 8 clks.
- Shadowing: change d1 from 1 to 3 at cnt = 3 → V1 for the remainder of the period is unchanged. The next period gives V1 = 00,00,00,01,00,00,00,11.
- Prescaler: DIV = 3, P = 8 → ce_out is a one-clk pulse every 3 clks, V1/V2 change only the clk before a ce_out, and the period spans 24 clks.
- Config error: P = 3, or P = 8 with phi = 8 → cfg_err = 1, V1 = V2 = 00, no sync, ce_out still pulsing. Restoring P = 8, phi = 2 clears cfg_err at the next tick.
- Clamp and odd period: P = 9, d1 = 5, d2 = 0, phi = 0:
  - V1 is constant 00;
  - V2 = 01 for counts 0..3 and 11 for counts 4..8;
  - cfg_err = 0.

Source files
------------

// File: rtl/dab_tps_modulator_if.sv
// Command bundle between the TPS carrier generator and its controller/consumer.
// master drives timing/enable and observes levels; slave is the modulator.
interface dab_tps_modulator_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] d1;
    logic [CNT_W-1:0] d2;
    logic [CNT_W-1:0] phi;
    logic [1:0]       V1;
    logic [1:0]       V2;
    logic             ce_out;
    logic             sync;
    logic             cfg_err;

    modport master (
        output en, period, d1, d2, phi,
        input  V1, V2, ce_out, sync, cfg_err
    );

    modport slave (
        input  en, period, d1, d2, phi,
        output V1, V2, ce_out, sync, cfg_err
    );
endinterface

// File: rtl/dab_tps_modulator.sv
// Triple-phase-shift carrier for the DAB bridges: three-level V1/V2 commands, shadowed timing.
// Levels registered 1 clk after a carrier tick, ce_out 1 clk later; no backpressure (free-running).
module dab_tps_modulator #(
    parameter int DIV   = 1,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    dab_tps_modulator_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]    r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_d1;
    logic [CNT_W-1:0] r_d2;
    logic [CNT_W-1:0] r_phi;
    logic             r_armed;
    logic             r_cfg_err;
    logic [1:0]       r_v1;
    logic [1:0]       r_v2;
    logic             r_sync;
    logic             r_tick_d;
    logic             r_ce;

    logic             w_tick;
    logic             w_wrap;
    logic             w_load;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_p_nxt;
    logic [CNT_W-1:0] w_d1_nxt;
    logic [CNT_W-1:0] w_d2_nxt;
    logic [CNT_W-1:0] w_phi_nxt;
    logic             w_err_nxt;
    logic             w_run;
    logic [CNT_W:0]   w_c2;

    function automatic logic cfg_bad(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] ph);
        return (p < CNT_W'(4)) || (ph >= p);
    endfunction

    // Zero band of width d at the start of each half; +1 in the first half, -1 in the second.
    function automatic logic [1:0] level(input logic [CNT_W:0] c, input logic [CNT_W-1:0] d,
                                         input logic [CNT_W-1:0] p);
        logic [CNT_W:0] h;
        h = {2'b00, p[CNT_W-1:1]};
        if (c < h) begin
            return (c < {1'b0, d}) ? 2'b00 : 2'b01;
        end
        return ((c - h) < {1'b0, d}) ? 2'b00 : 2'b11;
    endfunction

    assign w_tick = (r_pre == PW'(DIV - 1));
    assign w_wrap = (r_cnt == (r_p - 1'b1));

    // First enabled tick after a stop, or any tick while misconfigured, reloads and parks at 0.
    assign w_load    = !bus.en || !r_armed || r_cfg_err || w_wrap;
    assign w_cnt_nxt = w_load ? '0 : r_cnt + 1'b1;
    assign w_p_nxt   = w_load ? bus.period : r_p;
    assign w_d1_nxt  = w_load ? bus.d1     : r_d1;
    assign w_d2_nxt  = w_load ? bus.d2     : r_d2;
    assign w_phi_nxt = w_load ? bus.phi    : r_phi;
    assign w_err_nxt = cfg_bad(w_p_nxt, w_phi_nxt);
    assign w_run     = bus.en && !w_err_nxt;

    assign w_c2 = (w_cnt_nxt >= w_phi_nxt)
                ? ({1'b0, w_cnt_nxt} - {1'b0, w_phi_nxt})
                : ({1'b0, w_cnt_nxt} + {1'b0, w_p_nxt} - {1'b0, w_phi_nxt});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre     <= '0;
            r_cnt     <= '0;
            r_p       <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_phi     <= '0;
            r_armed   <= 1'b0;
            r_cfg_err <= 1'b1;
            r_v1      <= 2'b00;
            r_v2      <= 2'b00;
            r_sync    <= 1'b0;
            r_tick_d  <= 1'b0;
            r_ce      <= 1'b0;
        end else begin
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            r_tick_d <= w_tick;
            r_ce     <= r_tick_d;
            r_sync   <= 1'b0;
            if (w_tick) begin
                r_cnt     <= w_cnt_nxt;
                r_p       <= w_p_nxt;
                r_d1      <= w_d1_nxt;
                r_d2      <= w_d2_nxt;
                r_phi     <= w_phi_nxt;
                r_armed   <= bus.en;
                r_cfg_err <= w_err_nxt;
                r_v1      <= w_run ? level({1'b0, w_cnt_nxt}, w_d1_nxt, w_p_nxt) : 2'b00;
                r_v2      <= w_run ? level(w_c2, w_d2_nxt, w_p_nxt) : 2'b00;
                r_sync    <= w_run && (w_cnt_nxt == '0);
            end
        end
    end

    assign bus.V1      = r_v1;
    assign bus.V2      = r_v2;
    assign bus.sync    = r_sync;
    assign bus.ce_out  = r_ce;
    assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_dab_tps_modulator.sv
// Bench for dab_tps_modulator: DIV=1 and DIV=3 instances share stimulus and are
// compared every clk against a tick-level reference model plus directed pattern tables.
module tb_dab_tps_modulator;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             en_v;
    logic [CNT_W-1:0] period_v, d1_v, d2_v, phi_v;

    int n_chk;
    int n_pass;

    dab_tps_modulator_if #(.CNT_W(CNT_W)) ifa ();
    dab_tps_modulator_if #(.CNT_W(CNT_W)) ifb ();

    assign ifa.en = en_v;  assign ifa.period = period_v;
    assign ifa.d1 = d1_v;  assign ifa.d2 = d2_v;  assign ifa.phi = phi_v;
    assign ifb.en = en_v;  assign ifb.period = period_v;
    assign ifb.d1 = d1_v;  assign ifb.d2 = d2_v;  assign ifb.phi = phi_v;

    dab_tps_modulator #(.DIV(1), .CNT_W(CNT_W)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dab_tps_modulator #(.DIV(3), .CNT_W(CNT_W)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, one slot per instance
    int         div_k [2];
    int         m_pre [2], m_cnt [2], m_p [2], m_d1 [2], m_d2 [2], m_phi [2];
    bit         m_arm [2], m_tickd [2];
    logic [1:0] e_v1 [2], e_v2 [2];
    logic       e_sync [2], e_ce [2], e_err [2];

    function automatic bit cfg_bad(input int p, input int ph);
        return (p < 4) || (ph >= p);
    endfunction

    function automatic logic [1:0] lvl(input int c, input int d, input int p);
        int h;
        h = p / 2;
        if (c < h) return (c < d) ? 2'b00 : 2'b01;
        return ((c - h) < d) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pre[k] = 0; m_cnt[k] = 0; m_p[k] = 0; m_d1[k] = 0; m_d2[k] = 0; m_phi[k] = 0;
            m_arm[k] = 1'b0; m_tickd[k] = 1'b0;
            e_v1[k] = 2'b00; e_v2[k] = 2'b00; e_sync[k] = 1'b0; e_ce[k] = 1'b0; e_err[k] = 1'b1;
        end
    endtask

    task automatic model_edge(input int k);
        bit tick, hold, wrap, run;
        tick = (m_pre[k] == div_k[k] - 1);
        m_pre[k] = tick ? 0 : m_pre[k] + 1;
        e_ce[k] = m_tickd[k];
        m_tickd[k] = tick;
        e_sync[k] = 1'b0;
        if (tick) begin
            hold = !en_v || !m_arm[k] || cfg_bad(m_p[k], m_phi[k]);
            wrap = (m_cnt[k] == m_p[k] - 1);
            m_cnt[k] = hold ? 0 : (m_cnt[k] + 1) % m_p[k];
            if (hold || wrap) begin
                m_p[k] = int'(period_v); m_d1[k] = int'(d1_v);
                m_d2[k] = int'(d2_v);    m_phi[k] = int'(phi_v);
            end
            m_arm[k] = en_v;
            e_err[k] = cfg_bad(m_p[k], m_phi[k]);
            run = en_v && !e_err[k];
            e_v1[k] = run ? lvl(m_cnt[k], m_d1[k], m_p[k]) : 2'b00;
            e_v2[k] = run ? lvl((m_cnt[k] - m_phi[k] + m_p[k]) % m_p[k], m_d2[k], m_p[k]) : 2'b00;
            e_sync[k] = run && (m_cnt[k] == 0);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cmp_dut(input int k, input logic [1:0] v1, input logic [1:0] v2,
                           input logic sy, input logic ce, input logic er);
        chk($sformatf("v1_div%0d", div_k[k]),   16'(v1), 16'(e_v1[k]));
        chk($sformatf("v2_div%0d", div_k[k]),   16'(v2), 16'(e_v2[k]));
        chk($sformatf("sync_div%0d", div_k[k]), 16'(sy), 16'(e_sync[k]));
        chk($sformatf("ce_div%0d", div_k[k]),   16'(ce), 16'(e_ce[k]));
        chk($sformatf("err_div%0d", div_k[k]),  16'(er), 16'(e_err[k]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        cmp_dut(0, ifa.V1, ifa.V2, ifa.sync, ifa.ce_out, ifa.cfg_err);
        cmp_dut(1, ifb.V1, ifb.V2, ifb.sync, ifb.ce_out, ifb.cfg_err);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_v1a"}, 16'(ifa.V1), 16'd0);      chk({tag, "_v2a"}, 16'(ifa.V2), 16'd0);
        chk({tag, "_cea"}, 16'(ifa.ce_out), 16'd0);  chk({tag, "_sya"}, 16'(ifa.sync), 16'd0);
        chk({tag, "_era"}, 16'(ifa.cfg_err), 16'd1);
        chk({tag, "_v1b"}, 16'(ifb.V1), 16'd0);      chk({tag, "_v2b"}, 16'(ifb.V2), 16'd0);
        chk({tag, "_ceb"}, 16'(ifb.ce_out), 16'd0);  chk({tag, "_syb"}, 16'(ifb.sync), 16'd0);
        chk({tag, "_erb"}, 16'(ifb.cfg_err), 16'd1);
    endtask

    logic [1:0] tv1_basic [8];
    logic [1:0] tv2_basic [8];
    logic [1:0] tv1_wide  [8];

    initial begin
        int ce_cnt, last_sync, gap, idx;
        n_chk = 0; n_pass = 0;
        div_k[0] = 1; div_k[1] = 3;
        tv1_basic = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};
        tv2_basic = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        tv1_wide  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};

        rst = 1'b1; en_v = 1'b0;
        period_v = 16'd8; d1_v = 16'd1; d2_v = 16'd2; phi_v = 16'd2;
        model_reset();
        #4;
        chk_reset_outputs("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Idle with en low, then run the basic TPS pattern
        steps(10);
        en_v = 1'b1;
        steps(40);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("basic_v1", 16'(ifa.V1), 16'(tv1_basic[m_cnt[0]]));
            chk("basic_v2", 16'(ifa.V2), 16'(tv2_basic[m_cnt[0]]));
        end

        // DIV=3: sync-to-sync spacing is one full period of 24 clks
        last_sync = -1; gap = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ifb.sync === 1'b1) begin
                if (last_sync >= 0 && gap == 0) gap = i - last_sync;
                last_sync = i;
            end
        end
        chk("div3_period", 16'(gap), 16'd24);

        // Mid-period d1 change takes effect only after the wrap
        for (int i = 0; i < 20 && m_cnt[0] != 3; i++) step();
        d1_v = 16'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_cnt[0] == 0) break;
            chk("shadow_old_v1", 16'(ifa.V1), 16'(tv1_basic[m_cnt[0]]));
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk("shadow_new_v1", 16'(ifa.V1), 16'(tv1_wide[m_cnt[0]]));
        end
        d1_v = 16'd1;
        steps(30);

        // Config errors: short period, then phi == period
        period_v = 16'd3;
        steps(40);
        ce_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("p3_err_a", 16'(ifa.cfg_err), 16'd1);  chk("p3_err_b", 16'(ifb.cfg_err), 16'd1);
            chk("p3_v1_a", 16'(ifa.V1), 16'd0);        chk("p3_v2_b", 16'(ifb.V2), 16'd0);
            chk("p3_sync_a", 16'(ifa.sync), 16'd0);
            if (ifb.ce_out === 1'b1) ce_cnt++;
        end
        chk("p3_ce_pulses_b", 16'(ce_cnt), 16'd4);
        period_v = 16'd8; phi_v = 16'd8;
        steps(40);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("phi8_err_a", 16'(ifa.cfg_err), 16'd1);
            chk("phi8_v2_a", 16'(ifa.V2), 16'd0);
        end
        phi_v = 16'd2;
        step();
        chk("restore_err_a", 16'(ifa.cfg_err), 16'd0);
        steps(30);

        // Odd period with clamped primary zero width
        period_v = 16'd9; d1_v = 16'd5; d2_v = 16'd0; phi_v = 16'd0;
        steps(40);
        for (int i = 0; i < 18; i++) begin
            step();
            chk("odd_v1", 16'(ifa.V1), 16'd0);
            chk("odd_v2", 16'(ifa.V2), (m_cnt[0] < 4) ? 16'd1 : 16'd3);
            chk("odd_err", 16'(ifa.cfg_err), 16'd0);
        end

        // Randomised configurations, including invalid ones and en drops
        for (int blk = 0; blk < 25; blk++) begin
            period_v = 16'($urandom_range(2, 12));
            phi_v    = 16'($urandom_range(0, int'(period_v)));
            d1_v     = 16'($urandom_range(0, 8));
            d2_v     = 16'($urandom_range(0, 8));
            en_v     = ($urandom_range(0, 5) != 0);
            idx      = $urandom_range(10, 30);
            steps(idx);
        end
        en_v = 1'b1; period_v = 16'd8; d1_v = 16'd1; d2_v = 16'd2; phi_v = 16'd2;
        steps(30);

        // Asynchronous reset in the middle of a period
        @(posedge clk);
        model_edge(0); model_edge(1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        steps(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
